ipa_tile_ctx_loader: RTL and testbench

Per-tile context unpacker that sits directly downstream of the IPA context DMA, one instance per CGRA tile. It snoops the DMA's broadcast context-write bus (64-bit data, 23-bit address, write enable). It unpacks the dense 20-bit instruction bitstream into the tile's instruction memory and the packed 32-bit constants into the tile's constant memory. On the DMA's execute-enable pulse it reports load status and launches the tile.

---
 rtl/ipa_tile_ctx_loader.sv | 192 +++++++++++++++++++
 tb/tb_ipa_tile_ctx_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ipa_tile_ctx_loader.sv
// Per-tile context unpacker: snoops the DMA context-write bus and unpacks the
// 20-bit instruction stream and packed 32-bit constants into tile memories.
// Ports:
//   Clk, Reset (async, active-low)
//   wr_en_i/wr_addr_i/wr_data_i : DMA broadcast beat
//   exec_en_i                   : all-tiles-loaded pulse
//   imem_we_o/addr_o/data_o     : 4-lane instruction write port
//   cmem_we_o/addr_o/data_o     : 2-word constant write port
//   inst_count_o, exec_start_o, err_o : load status and launch
module ipa_tile_ctx_loader #(
  parameter int TILE_ID     = 0,
  parameter int INST_DEPTH  = 64,
  parameter int CONST_DEPTH = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        wr_en_i,
  input  logic [22:0] wr_addr_i,
  input  logic [63:0] wr_data_i,
  input  logic        exec_en_i,
  output logic [3:0]  imem_we_o,
  output logic [6:0]  imem_addr_o,
  output logic [79:0] imem_data_o,
  output logic        cmem_we_o,
  output logic [4:0]  cmem_addr_o,
  output logic [63:0] cmem_data_o,
  output logic [6:0]  inst_count_o,
  output logic        exec_start_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] IDEP = 8'(INST_DEPTH);
  localparam logic [5:0] CDEP = 6'(CONST_DEPTH);

  state_e      st_q, st_d, st_e;
  logic [18:0] res_q, res_d, res_e;
  logic [4:0]  rlen_q, rlen_d, rlen_e;
  logic [7:0]  iptr_q, iptr_d, iptr_e;
  logic [6:0]  exp_q, exp_d, exp_e;
  logic [6:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [3:0]  iwe_q, iwe_d;
  logic [6:0]  iadr_q, iadr_d;
  logic [79:0] idat_q, idat_d;
  logic        cwe_q, cwe_d;
  logic [4:0]  cadr_q, cadr_d;
  logic [63:0] cdat_q, cdat_d;
  logic        start_q, start_d;

  logic        acc_ok, ib, cb, idx0;
  logic [5:0]  idx;
  logic [3:0]  cidx;
  logic [82:0] acc;
  logic        four;
  logic [7:0]  ladr;

  assign acc_ok = wr_en_i && wr_addr_i[TILE_ID];
  assign ib     = acc_ok && !wr_addr_i[16];
  assign cb     = acc_ok && wr_addr_i[16];
  assign idx    = wr_addr_i[22:17];
  assign cidx   = wr_addr_i[20:17];
  assign idx0   = ib && (idx == 6'd0);

  // New beat lands above the residual bits; 4 instructions once r >= 16.
  assign acc  = ({19'd0, wr_data_i} << rlen_e) | {64'd0, res_q & {19{!idx0}}};
  assign four = (rlen_e >= 5'd16);

  always_comb begin
    st_e   = idx0 ? LOAD : st_q;
    rlen_e = idx0 ? 5'd0 : rlen_q;
    res_e  = idx0 ? 19'd0 : res_q;
    iptr_e = idx0 ? 8'd0 : iptr_q;
    exp_e  = idx0 ? 7'd0 : exp_q;
    st_d    = st_e;
    rlen_d  = rlen_e;
    res_d   = res_e;
    iptr_d  = iptr_e;
    exp_d   = exp_e;
    cnt_d   = idx0 ? 7'd0 : cnt_q;
    err_d   = idx0 ? 1'b0 : err_q;
    iwe_d   = '0;
    iadr_d  = '0;
    idat_d  = '0;
    cwe_d   = 1'b0;
    cadr_d  = '0;
    cdat_d  = '0;
    start_d = 1'b0;
    ladr    = '0;

    if (ib) begin
      if (st_e == LOAD && {1'b0, idx} == exp_e) begin
        for (int k = 0; k < 4; k++) begin
          ladr = iptr_e + 8'(k);
          if (k < 3 || four) begin
            if (ladr < IDEP) begin
              iwe_d[k]          = 1'b1;
              idat_d[20*k +: 20] = acc[20*k +: 20];
            end else begin
              err_d = 1'b1;
            end
          end
        end
        if (four) begin
          res_d  = acc[82:80] == 3'd0 ? 19'd0 : {16'd0, acc[82:80]};
          rlen_d = rlen_e - 5'd16;
          iptr_d = iptr_e + 8'd4;
        end else begin
          res_d  = acc[78:60];
          rlen_d = rlen_e + 5'd4;
          iptr_d = iptr_e + 8'd3;
        end
        if (iwe_d != 4'd0) iadr_d = iptr_e[6:0];
        cnt_d = (iptr_d >= IDEP) ? IDEP[6:0] : iptr_d[6:0];
        if (iptr_d >= IDEP && INST_DEPTH == 128) cnt_d = 7'd127;
        exp_d = exp_e + 7'd1;
      end else begin
        err_d = 1'b1;
      end
    end

    if (cb) begin
      if (st_e == DONE || {1'b0, cidx, 1'b0} >= CDEP) begin
        err_d = 1'b1;
      end else begin
        cwe_d  = 1'b1;
        cadr_d = {cidx, 1'b0};
        cdat_d = wr_data_i;
      end
    end

    // Trailing pad bits are dropped at launch.
    if (exec_en_i) begin
      rlen_d = 5'd0;
      res_d  = 19'd0;
      if (st_d != IDLE) begin
        st_d    = DONE;
        start_d = !err_d && (cnt_d != 7'd0);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      st_q    <= IDLE;
      res_q   <= '0;
      rlen_q  <= '0;
      iptr_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      iwe_q   <= '0;
      iadr_q  <= '0;
      idat_q  <= '0;
      cwe_q   <= 1'b0;
      cadr_q  <= '0;
      cdat_q  <= '0;
      start_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      res_q   <= res_d;
      rlen_q  <= rlen_d;
      iptr_q  <= iptr_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      iwe_q   <= iwe_d;
      iadr_q  <= iadr_d;
      idat_q  <= idat_d;
      cwe_q   <= cwe_d;
      cadr_q  <= cadr_d;
      cdat_q  <= cdat_d;
      start_q <= start_d;
    end
  end

  assign imem_we_o    = iwe_q;
  assign imem_addr_o  = iadr_q;
  assign imem_data_o  = idat_q;
  assign cmem_we_o    = cwe_q;
  assign cmem_addr_o  = cadr_q;
  assign cmem_data_o  = cdat_q;
  assign inst_count_o = cnt_q;
  assign exec_start_o = start_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ipa_tile_ctx_loader.sv
// Directed table-driven bench for ipa_tile_ctx_loader (TILE_ID = 2).
// Each row is one cycle of stimulus and the outputs expected after that edge.
module tb_ipa_tile_ctx_loader;

  localparam int TID = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [22:0] wr_addr_i = '0;
  logic [63:0] wr_data_i = '0;
  logic        exec_en_i = 1'b0;
  logic [3:0]  imem_we_o;
  logic [6:0]  imem_addr_o;
  logic [79:0] imem_data_o;
  logic        cmem_we_o;
  logic [4:0]  cmem_addr_o;
  logic [63:0] cmem_data_o;
  logic [6:0]  inst_count_o;
  logic        exec_start_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  ipa_tile_ctx_loader #(.TILE_ID(TID), .INST_DEPTH(64), .CONST_DEPTH(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .exec_en_i(exec_en_i),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
    .cmem_we_o(cmem_we_o), .cmem_addr_o(cmem_addr_o), .cmem_data_o(cmem_data_o),
    .inst_count_o(inst_count_o), .exec_start_o(exec_start_o), .err_o(err_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        en;
    logic [22:0] adr;
    logic [63:0] dat;
    logic        ex;
    logic [3:0]  we;
    logic [6:0]  ia;
    logic [79:0] id;
    logic        cwe;
    logic [4:0]  ca;
    logic [63:0] cd;
    logic [6:0]  cnt;
    logic        err;
    logic        st;
  } vec_t;

  vec_t tbl[$];

  localparam logic [15:0] ME = 16'h0004;
  localparam logic [79:0] ONES3 = {20'h0, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
  localparam logic [79:0] ONES4 = {4{20'hFFFFF}};

  function automatic logic [22:0] ia_(input int idx, input logic [15:0] m);
    return {6'(idx), 1'b0, m};
  endfunction

  function automatic logic [22:0] ca_(input int idx, input logic [15:0] m);
    return {2'b00, 4'(idx), 1'b1, m};
  endfunction

  task automatic add(input logic en, input logic [22:0] adr,
                     input logic [63:0] dat, input logic ex,
                     input logic [3:0] we, input logic [6:0] ia,
                     input logic [79:0] id, input logic cwe,
                     input logic [4:0] ca, input logic [63:0] cd,
                     input logic [6:0] cnt, input logic err, input logic st);
    vec_t v;
    v.en = en; v.adr = adr; v.dat = dat; v.ex = ex;
    v.we = we; v.ia = ia; v.id = id; v.cwe = cwe; v.ca = ca; v.cd = cd;
    v.cnt = cnt; v.err = err; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [79:0] got,
                     input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [22:0] adr,
                       input logic [63:0] dat, input logic ex);
    wr_en_i = en; wr_addr_i = adr; wr_data_i = dat; exec_en_i = ex;
    @(posedge Clk);
    #1;
    wr_en_i = 1'b0; exec_en_i = 1'b0;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, ".we"}, 80'(imem_we_o), 80'(v.we));
    chk({tag, ".ia"}, 80'(imem_addr_o), 80'(v.ia));
    chk({tag, ".id"}, imem_data_o, v.id);
    chk({tag, ".cwe"}, 80'(cmem_we_o), 80'(v.cwe));
    chk({tag, ".ca"}, 80'(cmem_addr_o), 80'(v.ca));
    chk({tag, ".cd"}, 80'(cmem_data_o), 80'(v.cd));
    chk({tag, ".cnt"}, 80'(inst_count_o), 80'(v.cnt));
    chk({tag, ".err"}, 80'(err_o), 80'(v.err));
    chk({tag, ".start"}, 80'(exec_start_o), 80'(v.st));
  endtask

  initial begin
    vec_t z;
    z = '{default: '0};

    // Five all-ones beats: 3,3,3,3,4 instructions.
    add(1, ia_(0, ME), '1, 0, 4'h7, 0,  ONES3, 0, 0, 0, 3,  0, 0);
    add(1, ia_(1, ME), '1, 0, 4'h7, 3,  ONES3, 0, 0, 0, 6,  0, 0);
    add(1, ia_(2, ME), '1, 0, 4'h7, 6,  ONES3, 0, 0, 0, 9,  0, 0);
    add(1, ia_(3, ME), '1, 0, 4'h7, 9,  ONES3, 0, 0, 0, 12, 0, 0);
    add(1, ia_(4, ME), '1, 0, 4'hF, 12, ONES4, 0, 0, 0, 16, 0, 0);
    add(0, '0, '0, 0, 0, 0, 0, 0, 0, 0, 16, 0, 0);
    add(0, '0, '0, 1, 0, 0, 0, 0, 0, 0, 16, 0, 1);
    add(0, '0, '0, 0, 0, 0, 0, 0, 0, 0, 16, 0, 0);
    // Single-bit stream: lane 0 only.
    add(1, ia_(0, ME), 64'h1, 0, 4'h7, 0, 80'h1, 0, 0, 0, 3, 0, 0);
    add(1, ia_(1, ME), 64'h0, 0, 4'h7, 3, 80'h0, 0, 0, 0, 6, 0, 0);
    // Constants, incl. top legal pair.
    add(1, ca_(3, ME), 64'h11111111_22222222, 0, 0, 0, 0,
        1, 5'd6, 64'h11111111_22222222, 6, 0, 0);
    add(1, ca_(15, ME), 64'h5, 0, 0, 0, 0, 1, 5'd30, 64'h5, 6, 0, 0);
    // Other tile only: ignored. Broadcast: accepted.
    add(1, ia_(2, 16'h0001), '1, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0);
    add(1, ia_(2, 16'hFFFF), '0, 0, 4'h7, 6, 0, 0, 0, 0, 9, 0, 0);
    // Skipped index 3 -> error, no launch.
    add(1, ia_(4, ME), '1, 0, 0, 0, 0, 0, 0, 0, 9, 1, 0);
    add(0, '0, '0, 1, 0, 0, 0, 0, 0, 0, 9, 1, 0);
    // Clean 2-beat load with exec alongside beat 1.
    add(1, ia_(0, ME), '0, 0, 4'h7, 0, 0, 0, 0, 0, 3, 0, 0);
    add(1, ia_(1, ME), '0, 1, 4'h7, 3, 0, 0, 0, 0, 6, 0, 1);
    add(0, '0, '0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0);
    // Constant in DONE is an error; exec then refuses launch.
    add(1, ca_(1, ME), 64'h7, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0);
    add(0, '0, '0, 1, 0, 0, 0, 0, 0, 0, 6, 1, 0);
    // Restart, launch with pad bits, then a late beat is an error.
    add(1, ia_(0, ME), '1, 0, 4'h7, 0, ONES3, 0, 0, 0, 3, 0, 0);
    add(0, '0, '0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1);
    add(1, ia_(1, ME), '1, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0);

    Reset = 1'b0;
    #12;
    check_all("reset", z);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    // exec in IDLE: nothing happens.
    drive(0, '0, '0, 1);
    check_all("idle_exec", z);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].adr, tbl[i].dat, tbl[i].ex);
      check_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Fill exactly 64 instructions, then overflow.
    for (int b = 0; b < 20; b++) drive(1, ia_(b, ME), '1, 0);
    chk("fill.we", 80'(imem_we_o), 80'h F);
    chk("fill.ia", 80'(imem_addr_o), 80'd60);
    chk("fill.cnt", 80'(inst_count_o), 80'd64);
    chk("fill.err", 80'(err_o), 80'd0);
    drive(1, ia_(20, ME), '1, 0);
    chk("ovf.we", 80'(imem_we_o), 80'h0);
    chk("ovf.cnt", 80'(inst_count_o), 80'd64);
    chk("ovf.err", 80'(err_o), 80'd1);

    // Reset during beat 2 of a load.
    drive(1, ia_(0, ME), '1, 0);
    drive(1, ia_(1, ME), '1, 0);
    wr_en_i = 1'b1; wr_addr_i = ia_(2, ME); wr_data_i = '1;
    Reset = 1'b0;
    #1;
    check_all("rst_mid", z);
    wr_en_i = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    drive(1, ia_(1, ME), '1, 0);
    chk("rst_idx1.err", 80'(err_o), 80'd1);
    chk("rst_idx1.we", 80'(imem_we_o), 80'd0);
    drive(1, ia_(0, ME), 64'hABC, 0);
    chk("rst_re.we", 80'(imem_we_o), 80'h7);
    chk("rst_re.ia", 80'(imem_addr_o), 80'd0);
    chk("rst_re.id", imem_data_o, 80'hABC);
    chk("rst_re.err", 80'(err_o), 80'd0);
    chk("rst_re.cnt", 80'(inst_count_o), 80'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
